// File: rtl/rf_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rf_ctrl_pkg
// Shared definitions for the register-file access controller: field widths,
// opcode values, FSM state encoding, write-back / ALU select codes and the
// packed bundle of registered control outputs.
//
// Optional feature macro: RF_LOADI_EN (enables opcode 6, LOADI).
// ----------------------------------------------------------------------------
package rf_ctrl_pkg;

    localparam int RF_IW  = 16;  // instruction width
    localparam int RF_AW  = 4;   // register address width
    localparam int RF_DAW = 8;   // data-memory address width

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;
    localparam logic [3:0] OP_LOADI = 4'd6;

    localparam logic [1:0] RF_SEL_ALU = 2'd0;
    localparam logic [1:0] RF_SEL_MEM = 2'd1;
    localparam logic [1:0] RF_SEL_IMM = 2'd2;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_STORE  = 3'd3,
        ST_LD_A   = 3'd4,
        ST_LD_B   = 3'd5,
        ST_HALT   = 3'd6,
        ST_LOADI  = 3'd7
    } rf_state_e;

    // Every control output the FSM drives, registered as one bundle.
    typedef struct packed {
        logic              ready;
        logic [RF_AW-1:0]  w_addr;
        logic              w_en;
        logic [RF_AW-1:0]  ra_addr;
        logic              ra_en;
        logic [RF_AW-1:0]  rb_addr;
        logic              rb_en;
        logic [1:0]        rf_sel;
        logic [1:0]        alu_sel;
        logic [RF_DAW-1:0] d_addr;
        logic              d_wr;
        logic              halted;
        logic              err;
    } rf_ctrl_out_t;

endpackage

// File: rtl/rf_instr_field_decode.sv
// ----------------------------------------------------------------------------
// rf_instr_field_decode
// Combinational split of an instruction word into its fields plus a legality
// flag.
//
// Ports:
//   ir_i        in   16  instruction word [15:12] op, [11:8] A, [7:4] B, [3:0] D
//   op_o        out  4   opcode
//   a_o/b_o/d_o out  4   register fields
//   mem_addr_o  out  8   data-memory address {A,B}
//   legal_o     out  1   opcode is implemented in this build
//
// Optional feature macro: RF_LOADI_EN (makes opcode 6 legal).
// ----------------------------------------------------------------------------
module rf_instr_field_decode
    import rf_ctrl_pkg::*;
(
    input  logic [RF_IW-1:0]  ir_i,
    output logic [3:0]        op_o,
    output logic [RF_AW-1:0]  a_o,
    output logic [RF_AW-1:0]  b_o,
    output logic [RF_AW-1:0]  d_o,
    output logic [RF_DAW-1:0] mem_addr_o,
    output logic              legal_o
);

    assign op_o       = ir_i[15:12];
    assign a_o        = ir_i[11:8];
    assign b_o        = ir_i[7:4];
    assign d_o        = ir_i[3:0];
    assign mem_addr_o = ir_i[11:4];

    always_comb begin
        legal_o = 1'b0;
        case (op_o)
            OP_NOOP, OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_HALT: legal_o = 1'b1;
`ifdef RF_LOADI_EN
            OP_LOADI: legal_o = 1'b1;
`endif
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/rf_access_controller.sv
// ----------------------------------------------------------------------------
// rf_access_controller
// Control FSM that accepts 16-bit instructions over a valid/ready handshake,
// decodes them and drives the register-file read/write ports, data-memory
// address/strobe, ALU select and write-back select.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both 1. instr_ready is 1 only in IDLE, so there is never a
// back-to-back accept and valid without ready is never captured.
//
// Ports:
//   Clk, Rst            clock, synchronous active-low reset
//   instr_valid/ready   instruction handshake
//   instr               [15:12] op, [11:8] A, [7:4] B, [3:0] D
//   W_addr/W_en         register write port
//   Ra_addr/Ra_en       register read port A
//   Rb_addr/Rb_en       register read port B
//   RF_sel              write-back source 0 ALU, 1 MEM, 2 IMM
//   ALU_sel             0 PASS, 1 ADD, 2 SUB
//   D_addr/D_wr         data-memory address and write strobe
//   halted              high in HALT (left only by reset)
//   err                 one-cycle pulse on an illegal opcode
//   instr_count         retired-instruction counter (wraps)
//   dbg_state           current FSM state encoding
//
// Optional feature macro: RF_LOADI_EN (opcode 6, LOADI R[D] <= {A,B}).
// ----------------------------------------------------------------------------
module rf_access_controller
    import rf_ctrl_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [RF_IW-1:0]  instr,
    output logic [RF_AW-1:0]  W_addr,
    output logic              W_en,
    output logic [RF_AW-1:0]  Ra_addr,
    output logic              Ra_en,
    output logic [RF_AW-1:0]  Rb_addr,
    output logic              Rb_en,
    output logic [1:0]        RF_sel,
    output logic [1:0]        ALU_sel,
    output logic [RF_DAW-1:0] D_addr,
    output logic              D_wr,
    output logic              halted,
    output logic              err,
    output logic [15:0]       instr_count,
    output logic [2:0]        dbg_state
);

    rf_state_e    state_q, state_d;
    logic [15:0]  ir_q, ir_d;
    logic [15:0]  count_q, count_d;
    rf_ctrl_out_t out_q, out_d;
    logic         accept;

    logic [3:0]        f_op;
    logic [RF_AW-1:0]  f_a, f_b, f_d;
    logic [RF_DAW-1:0] f_mem;
    logic              f_legal;

    // The decoder looks at the next IR. Outside IDLE the IR is not
    // reloaded, so in DECODE ir_d equals ir_q and the same fields serve the
    // transition decision and the next-state output decode.
    rf_instr_field_decode u_dec (
        .ir_i       (ir_d),
        .op_o       (f_op),
        .a_o        (f_a),
        .b_o        (f_b),
        .d_o        (f_d),
        .mem_addr_o (f_mem),
        .legal_o    (f_legal)
    );

    assign accept = instr_valid && out_q.ready;
    assign ir_d   = accept ? instr : ir_q;

    // Next state and retire counting.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                if (f_legal) begin
                    case (f_op)
                        OP_STORE: state_d = ST_STORE;
                        OP_LOAD:  state_d = ST_LD_A;
                        OP_ADD,
                        OP_SUB:   state_d = ST_EXEC;
                        OP_HALT: begin
                            state_d = ST_HALT;
                            count_d = count_q + 16'd1;
                        end
`ifdef RF_LOADI_EN
                        OP_LOADI: state_d = ST_LOADI;
`endif
                        default: begin
                            // NOOP retires straight out of DECODE
                            state_d = ST_IDLE;
                            count_d = count_q + 16'd1;
                        end
                    endcase
                end
            end
            ST_EXEC, ST_STORE, ST_LD_B, ST_LOADI: begin
                state_d = ST_IDLE;
                count_d = count_q + 16'd1;
            end
            ST_LD_A: state_d = ST_LD_B;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore decode of (next state, next IR); registered so every output is
    // a clean flop and all of them read 0 right after a reset edge.
    always_comb begin
        out_d = '0;
        case (state_d)
            ST_IDLE:   out_d.ready = 1'b1;
            ST_DECODE: out_d.err   = !f_legal;
            ST_EXEC: begin
                out_d.ra_en   = 1'b1;
                out_d.ra_addr = f_a;
                out_d.rb_en   = 1'b1;
                out_d.rb_addr = f_b;
                out_d.w_en    = 1'b1;
                out_d.w_addr  = f_d;
                out_d.rf_sel  = RF_SEL_ALU;
                out_d.alu_sel = (f_op == OP_SUB) ? ALU_SUB : ALU_ADD;
            end
            ST_STORE: begin
                // R[D] flows through the ALU in PASS mode to the memory
                out_d.ra_en   = 1'b1;
                out_d.ra_addr = f_d;
                out_d.d_addr  = f_mem;
                out_d.d_wr    = 1'b1;
                out_d.alu_sel = ALU_PASS;
            end
            ST_LD_A: out_d.d_addr = f_mem;
            ST_LD_B: begin
                // address held so the synchronous RAM output stays stable
                out_d.d_addr = f_mem;
                out_d.w_en   = 1'b1;
                out_d.w_addr = f_d;
                out_d.rf_sel = RF_SEL_MEM;
            end
            ST_LOADI: begin
                out_d.w_en   = 1'b1;
                out_d.w_addr = f_d;
                out_d.rf_sel = RF_SEL_IMM;
            end
            ST_HALT: out_d.halted = 1'b1;
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            count_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            count_q <= count_d;
            out_q   <= out_d;
        end
    end

    assign instr_ready = out_q.ready;
    assign W_addr      = out_q.w_addr;
    assign W_en        = out_q.w_en;
    assign Ra_addr     = out_q.ra_addr;
    assign Ra_en       = out_q.ra_en;
    assign Rb_addr     = out_q.rb_addr;
    assign Rb_en       = out_q.rb_en;
    assign RF_sel      = out_q.rf_sel;
    assign ALU_sel     = out_q.alu_sel;
    assign D_addr      = out_q.d_addr;
    assign D_wr        = out_q.d_wr;
    assign halted      = out_q.halted;
    assign err         = out_q.err;
    assign instr_count = count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_rf_access_controller.sv
// ----------------------------------------------------------------------------
// tb_rf_access_controller
// Drives directed and random instructions into rf_access_controller and
// compares every cycle of its outputs against a per-opcode timeline model.
// ----------------------------------------------------------------------------
module tb_rf_access_controller;

    // ---------------- clock / reset ----------------
    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0000;

    always #5 Clk = ~Clk;

    logic        instr_ready;
    logic [3:0]  W_addr, Ra_addr, Rb_addr;
    logic        W_en, Ra_en, Rb_en;
    logic [1:0]  RF_sel, ALU_sel;
    logic [7:0]  D_addr;
    logic        D_wr, halted, err;
    logic [15:0] instr_count;
    logic [2:0]  dbg_state;

    rf_access_controller dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .W_addr      (W_addr),
        .W_en        (W_en),
        .Ra_addr     (Ra_addr),
        .Ra_en       (Ra_en),
        .Rb_addr     (Rb_addr),
        .Rb_en       (Rb_en),
        .RF_sel      (RF_sel),
        .ALU_sel     (ALU_sel),
        .D_addr      (D_addr),
        .D_wr        (D_wr),
        .halted      (halted),
        .err         (err),
        .instr_count (instr_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [15:0] model_count = 16'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output bundle, same field order for model and observation.
    function automatic logic [31:0] vec(input logic w_en, input logic [3:0] w_addr,
                                        input logic ra_en, input logic [3:0] ra_addr,
                                        input logic rb_en, input logic [3:0] rb_addr,
                                        input logic [1:0] rf_sel, input logic [1:0] alu_sel,
                                        input logic [7:0] d_addr, input logic d_wr,
                                        input logic hlt, input logic er, input logic rdy);
        return {1'b0, w_en, w_addr, ra_en, ra_addr, rb_en, rb_addr, rf_sel, alu_sel,
                d_addr, d_wr, hlt, er, rdy};
    endfunction

    function automatic logic [31:0] observed();
        return vec(W_en, W_addr, Ra_en, Ra_addr, Rb_en, Rb_addr, RF_sel, ALU_sel,
                   D_addr, D_wr, halted, err, instr_ready);
    endfunction

    function automatic logic [31:0] idle_vec();
        return vec(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1);
    endfunction

    function automatic logic [31:0] zero_vec();
        return vec(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
`ifdef RF_LOADI_EN
        return op <= 4'd6;
`else
        return op <= 4'd5;
`endif
    endfunction

    // Timeline of one instruction after its accept edge: the DECODE cycle,
    // then whatever action cycles the opcode needs (HALT handled apart).
    function automatic void push_trace(input logic [15:0] ins);
        logic [3:0] op, a, b, d;
        logic [7:0] mem;
        op = ins[15:12]; a = ins[11:8]; b = ins[7:4]; d = ins[3:0]; mem = ins[11:4];
        exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, !is_legal(op), 0));
        if (is_legal(op)) begin
            case (op)
                4'd1: exp_q.push_back(vec(0, 0, 1, d, 0, 0, 0, 0, mem, 1, 0, 0, 0));
                4'd2: begin
                    exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, mem, 0, 0, 0, 0));
                    exp_q.push_back(vec(1, d, 0, 0, 0, 0, 1, 0, mem, 0, 0, 0, 0));
                end
                4'd3: exp_q.push_back(vec(1, d, 1, a, 1, b, 0, 1, 8'h00, 0, 0, 0, 0));
                4'd4: exp_q.push_back(vec(1, d, 1, a, 1, b, 0, 2, 8'h00, 0, 0, 0, 0));
                4'd6: exp_q.push_back(vec(1, d, 0, 0, 0, 0, 2, 0, 8'h00, 0, 0, 0, 0));
                default: ;
            endcase
        end
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge with the DUT idle. Random valid/instr noise is
    // driven while busy; the DUT must ignore it.
    task automatic issue(input string tag, input logic [15:0] ins);
        instr_valid = 1'b1;
        instr       = ins;
        @(negedge Clk);
        push_trace(ins);
        check_eq({tag, ".count_busy"}, {16'h0, instr_count}, {16'h0, model_count});
        while (exp_q.size() > 0) begin
            check_eq({tag, ".cycle"}, observed(), exp_q.pop_front());
            instr_valid = 1'($urandom_range(0, 1));
            instr       = 16'($urandom);
            @(negedge Clk);
        end
        instr_valid = 1'b0;
        if (is_legal(ins[15:12])) model_count = model_count + 16'd1;
        check_eq({tag, ".idle"}, observed(), idle_vec());
        check_eq({tag, ".count"}, {16'h0, instr_count}, {16'h0, model_count});
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            instr_valid = 1'b0;
            instr       = 16'($urandom);
            @(negedge Clk);
            check_eq("gap.idle", observed(), idle_vec());
        end
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        @(negedge Clk);
        model_count = 16'd0;
        check_eq("reset.outputs", observed(), zero_vec());
        check_eq("reset.count", {16'h0, instr_count}, 32'h0);
        Rst = 1'b1;
        @(negedge Clk);
        check_eq("release.idle", observed(), idle_vec());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  op;
        logic [15:0] ins;

        do_reset();

        issue("add", 16'h3125);
        issue("load", 16'h21A7);
        issue("store", 16'h13C4);
        issue("sub", 16'h4A5F);
        issue("noop", 16'h0000);
        issue("illegal9", 16'h9000);
        issue("op6", 16'h6012);
        idle_gap(2);

        for (int k = 0; k < 60; k++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd5) op = 4'd0;
            ins = {op, 12'($urandom)};
            issue("rand", ins);
            idle_gap($urandom_range(0, 2));
        end

        // reset while LOAD 0x2FF3 sits in LD_A: write must never happen
        instr_valid = 1'b1;
        instr       = 16'h2FF3;
        @(negedge Clk);
        instr_valid = 1'b0;
        check_eq("ldreset.decode", observed(), vec(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        @(negedge Clk);
        check_eq("ldreset.ld_a", observed(), vec(0, 0, 0, 0, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 0));
        do_reset();
        idle_gap(2);

        // HALT with valid held high for 10 cycles
        issue("add2", 16'h3125);
        instr_valid = 1'b1;
        instr       = 16'h5000;
        @(negedge Clk);
        check_eq("halt.decode", observed(), zero_vec());
        model_count = model_count + 16'd1;
        for (int i = 0; i < 10; i++) begin
            instr_valid = 1'b1;
            instr       = (i % 2 == 0) ? 16'h3125 : 16'($urandom);
            @(negedge Clk);
            check_eq("halt.hold", observed(), vec(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0));
            check_eq("halt.count", {16'h0, instr_count}, {16'h0, model_count});
        end
        instr_valid = 1'b0;
        do_reset();
        issue("add3", 16'h3125);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
